// File: rtl/cpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
//   Shared definitions for the single-cycle core's step controller.
//   - STATE_W : width of the FSM state as it is driven onto the board LEDs.
//   - state_e : FSM encoding. The numeric values are visible on the LEDs, so
//               they are fixed and must not be reordered.
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_HALT = 2'd0,  // idle, waiting for a step press or the run switch
    S_STEP = 2'd1,  // one-instruction step in progress
    S_RUN  = 2'd2,  // free-running at the divided rate
    S_STOP = 2'd3   // stopped on ebreak/ecall or breakpoint
  } state_e;

endpackage : cpu_ctrl_pkg

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//   Turns a raw, bouncing, asynchronous pushbutton into a single-cycle pulse on
//   each accepted press. Reusable for any board button.
//
//   Path: 2-flop synchronizer -> stability counter -> registered pulse.
//   A new level is accepted once the synchronized input has differed from the
//   accepted level for DEBOUNCE_CYCLES consecutive cycles. Only a 0->1
//   acceptance produces a pulse; releases are debounced silently.
//
// Parameters
//   DEBOUNCE_CYCLES : stable cycles required before a new level is accepted
//                     (must be >= 1).
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active low
//   btn_raw    in   raw pushbutton level (asynchronous)
//   step_pulse out  one-cycle pulse per accepted press
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic step_pulse
);

  logic        r_sync1;
  logic        r_sync2;
  logic        r_stable;   // last accepted button level
  logic        r_pulse;
  logic [15:0] r_cnt;      // consecutive cycles r_sync2 has differed from r_stable

  logic        w_differs;
  logic        w_accept;

  assign w_differs = (r_sync2 != r_stable);
  // The cycle being evaluated is the DEBOUNCE_CYCLES-th differing sample.
  assign w_accept  = w_differs && (r_cnt == (DEBOUNCE_CYCLES - 16'd1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others; blocking here would collapse the
  // synchronizer into a single stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_pulse  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;

      if (!w_differs) begin
        // Any sample matching the accepted level restarts the stability window.
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt    <= '0;
        r_stable <= r_sync2;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end

      r_pulse <= w_accept && r_sync2;
    end
  end

  assign step_pulse = r_pulse;

endmodule : btn_debounce

// File: rtl/cpu_step_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_step_ctrl
//   Clock-enable sequencer for the single-cycle RISC-V core. Decides when the
//   core retires one instruction: on a debounced step press, continuously at a
//   divided rate while the run switch is on, or not at all once the core hits
//   ebreak/ecall (or a PC breakpoint).
//
// Configuration macro
//   CPU_BREAKPOINT_EN : when defined, a PC match against bp_addr (with
//                       bp_valid) also stops free-run. When undefined the
//                       breakpoint ports are accepted but ignored and no
//                       comparator is built.
//
// Parameters
//   DEBOUNCE_CYCLES : button stability window in clk cycles
//   RUN_DIV         : free-run rate, one cpu_ce every RUN_DIV cycles (>= 1)
//   CNT_W           : width of the retired-instruction counter
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active low
//   step_btn   in   raw step pushbutton
//   run_sw     in   1 requests free-run
//   halt_req   in   instruction at current PC is ebreak/ecall
//   pc         in   current core PC
//   bp_addr    in   breakpoint address
//   bp_valid   in   breakpoint armed
//   cpu_ce     out  registered core clock enable
//   halted     out  registered, high in S_STOP
//   state      out  registered FSM state (LEDs)
//   cycle_cnt  out  registered count of cpu_ce pulses (wraps)
// -----------------------------------------------------------------------------
module cpu_step_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] RUN_DIV         = 24'd1,
  parameter int          CNT_W           = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step_btn,
  input  logic               run_sw,
  input  logic               halt_req,
  input  logic [31:0]        pc,
  input  logic [31:0]        bp_addr,
  input  logic               bp_valid,
  output logic               cpu_ce,
  output logic               halted,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   cycle_cnt
);

  state_e           r_state;
  state_e           w_state_next;
  logic [23:0]      r_div;
  logic [23:0]      w_div_next;
  logic             r_cpu_ce;
  logic             w_ce_next;
  logic             r_halted;
  logic [CNT_W-1:0] r_cnt;

  logic             w_step_pulse;
  logic             w_bp_hit;
  logic             w_stop_cond;
  logic             w_issue_slot;

  // ---------------------------------------------------------------------------
  // Step button
  // ---------------------------------------------------------------------------
  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (step_btn),
    .step_pulse (w_step_pulse)
  );

  // ---------------------------------------------------------------------------
  // Stop condition. halt_req and pc come straight from the core and are
  // evaluated in the issue-slot cycle itself, so the stopping instruction is
  // never enabled.
  // ---------------------------------------------------------------------------
`ifdef CPU_BREAKPOINT_EN
  assign w_bp_hit = bp_valid && (pc == bp_addr);
`else
  // Breakpoint ports stay on the interface so the board top is identical in
  // both builds; they are deliberately unused here.
  logic w_unused_bp;
  assign w_unused_bp = ^{pc, bp_addr, bp_valid};
  assign w_bp_hit    = 1'b0;
`endif

  assign w_stop_cond  = halt_req || w_bp_hit;
  assign w_issue_slot = (r_div == (RUN_DIV - 24'd1));

  // ---------------------------------------------------------------------------
  // FSM next-state / next-output logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default before the case statement;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_ce_next    = 1'b0;
    w_div_next   = '0;   // divider is zero outside S_RUN, so entry starts clean

    case (r_state)
      S_HALT: begin
        // Run switch outranks a coincident step press.
        if (run_sw) begin
          w_state_next = S_RUN;
        end else if (w_step_pulse) begin
          w_state_next = S_STEP;
          w_ce_next    = 1'b1;
        end
      end

      S_STEP: begin
        // cpu_ce was raised on entry; halt_req/breakpoint are ignored so the
        // user can step over the instruction that stopped the run.
        w_state_next = S_HALT;
      end

      S_RUN: begin
        // Stop at an issue slot outranks the run switch being turned off.
        if (w_issue_slot && w_stop_cond) begin
          w_state_next = S_STOP;
        end else if (!run_sw) begin
          w_state_next = S_HALT;
        end else begin
          w_ce_next  = w_issue_slot;
          w_div_next = w_issue_slot ? '0 : (r_div + 24'd1);
        end
      end

      S_STOP: begin
        if (!run_sw) begin
          w_state_next = S_HALT;
        end
      end

      default: begin
        w_state_next = S_HALT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_HALT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs, divider and retired-instruction counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div    <= '0;
      r_cpu_ce <= 1'b0;
      r_halted <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_div    <= w_div_next;
      r_cpu_ce <= w_ce_next;
      r_halted <= (w_state_next == S_STOP);
      // Counts the enables the core has actually seen; wraps naturally.
      if (r_cpu_ce) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign cpu_ce    = r_cpu_ce;
  assign halted    = r_halted;
  assign state     = r_state;
  assign cycle_cnt = r_cnt;

endmodule : cpu_step_ctrl

// File: tb/tb_cpu_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_step_ctrl
//   Self-checking bench for cpu_step_ctrl with DEBOUNCE_CYCLES=4, RUN_DIV=3,
//   CNT_W=4. Inputs change on the falling edge; outputs are sampled on the
//   falling edge, half a cycle away from the active edge.
// -----------------------------------------------------------------------------
module tb_cpu_step_ctrl;

  localparam int DEB   = 4;
  localparam int DIV   = 3;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             step_btn;
  logic             run_sw;
  logic             halt_req;
  logic [31:0]      pc;
  logic [31:0]      bp_addr;
  logic             bp_valid;
  logic             cpu_ce;
  logic             halted;
  logic [1:0]       state;
  logic [CNT_W-1:0] cycle_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES (16'd4),
    .RUN_DIV         (24'd3),
    .CNT_W           (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .step_btn  (step_btn),
    .run_sw    (run_sw),
    .halt_req  (halt_req),
    .pc        (pc),
    .bp_addr   (bp_addr),
    .bp_valid  (bp_valid),
    .cpu_ce    (cpu_ce),
    .halted    (halted),
    .state     (state),
    .cycle_cnt (cycle_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: behaviour from the written rules. Button acceptance is a
  // window over the last DEB synchronized samples; run pacing is the age in
  // S_RUN modulo RUN_DIV.
  // ---------------------------------------------------------------------------
  typedef enum int {M_IDLE, M_STEP, M_RUN, M_STOP} mode_t;

  mode_t m_mode;
  int    m_age;
  int    m_cnt;
  bit    m_ce;
  bit    m_halted;
  bit    m_acc;     // accepted button level
  bit    m_pulse;   // step pulse visible to the FSM at the next edge
  bit    m_hist[$]; // raw button samples taken at past edges, newest last

  function automatic logic [1:0] mode_code(input mode_t m);
    case (m)
      M_IDLE:  return 2'd0;
      M_STEP:  return 2'd1;
      M_RUN:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_age = 0; m_cnt = 0; m_ce = 0; m_halted = 0;
    m_acc = 0; m_pulse = 0;
    m_hist.delete();
    repeat (DEB + 2) m_hist.push_back(1'b0);
  endtask

  // Predicts the effect of the next rising edge given the currently driven inputs.
  task automatic model_edge();
    bit bp, stop, slot, new_ce, all_new;
`ifdef CPU_BREAKPOINT_EN
    bp = bp_valid && (pc == bp_addr);
`else
    bp = 1'b0;
`endif
    stop   = halt_req || bp;
    new_ce = 1'b0;
    m_cnt  = (m_cnt + int'(m_ce)) % (1 << CNT_W);
    case (m_mode)
      M_IDLE: begin
        if (run_sw) begin m_mode = M_RUN; m_age = 0; end
        else if (m_pulse) begin m_mode = M_STEP; new_ce = 1'b1; end
      end
      M_STEP: m_mode = M_IDLE;
      M_RUN: begin
        slot = (m_age % DIV) == (DIV - 1);
        if (slot && stop) m_mode = M_STOP;
        else if (!run_sw) m_mode = M_IDLE;
        else begin new_ce = slot; m_age++; end
      end
      default: if (!run_sw) m_mode = M_IDLE;
    endcase
    m_ce     = new_ce;
    m_halted = (m_mode == M_STOP);
    // Synchronizer delay: the sample judged at this edge was taken two edges ago.
    all_new = 1'b1;
    for (int j = 0; j < DEB; j++)
      if (m_hist[m_hist.size() - 2 - j] == m_acc) all_new = 1'b0;
    m_pulse = all_new && !m_acc;
    if (all_new) m_acc = !m_acc;
    m_hist.push_back(step_btn);
    void'(m_hist.pop_front());
  endtask

  task automatic tick();
    model_edge();
    @(negedge clk);
  endtask

  task automatic check_model();
    check("rand_cpu_ce", 32'(cpu_ce), 32'(m_ce));
    check("rand_halted", 32'(halted), 32'(m_halted));
    check("rand_state", 32'(state), 32'(mode_code(m_mode)));
    check("rand_cycle_cnt", 32'(cycle_cnt), 32'(m_cnt));
  endtask

  // Called at a falling edge; asserts reset, checks outputs clear at once.
  task automatic do_reset();
    run_sw = 0; halt_req = 0; step_btn = 0; bp_valid = 0; pc = '0; bp_addr = '0;
    rst = 1'b0;
    #1;
    check("rst_cpu_ce", 32'(cpu_ce), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_state", 32'(state), 0);
    check("rst_cycle_cnt", 32'(cycle_cnt), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Run/halt table: one row per clock, expected outputs after that edge.
  typedef struct {
    bit       run_sw;
    bit       halt_req;
    bit       exp_ce;
    bit [1:0] exp_state;
    bit       exp_halted;
    int       exp_cnt;
  } vec_t;

  vec_t tbl[26];

  initial begin
    int n, first, guard;
    bit saw_step;
    int hold;

    tbl[0]  = '{1,0,0,2,0,0}; tbl[1]  = '{1,0,0,2,0,0}; tbl[2]  = '{1,0,0,2,0,0};
    tbl[3]  = '{1,0,1,2,0,0}; tbl[4]  = '{1,0,0,2,0,1}; tbl[5]  = '{1,0,0,2,0,1};
    tbl[6]  = '{1,0,1,2,0,1}; tbl[7]  = '{1,0,0,2,0,2}; tbl[8]  = '{1,0,0,2,0,2};
    tbl[9]  = '{1,0,1,2,0,2}; tbl[10] = '{1,0,0,2,0,3}; tbl[11] = '{1,0,0,2,0,3};
    tbl[12] = '{1,0,1,2,0,3}; tbl[13] = '{1,0,0,2,0,4}; tbl[14] = '{1,0,0,2,0,4};
    tbl[15] = '{1,1,0,3,1,4}; // halt_req at issue slot: no enable, stop
    tbl[16] = '{1,0,0,3,1,4}; // stays stopped while run_sw is on
    tbl[17] = '{0,0,0,0,0,4};
    tbl[18] = '{1,0,0,2,0,4}; tbl[19] = '{1,0,0,2,0,4};
    tbl[20] = '{0,0,0,0,0,4}; // run_sw off mid-divider
    tbl[21] = '{1,0,0,2,0,4}; tbl[22] = '{1,0,0,2,0,4}; tbl[23] = '{1,0,0,2,0,4};
    tbl[24] = '{0,1,0,3,1,4}; // stop and run_sw off together: stop wins
    tbl[25] = '{0,0,0,0,0,4};

    rst = 1'b1; run_sw = 0; halt_req = 0; step_btn = 0; bp_valid = 0;
    pc = '0; bp_addr = '0;
    @(negedge clk);
    do_reset();

    // Clean 10-cycle press: one enable, 7 cycles after the press edge.
    step_btn = 1; n = 0; first = -1;
    for (int i = 1; i <= 20; i++) begin
      if (i == 11) step_btn = 0;
      tick();
      if (cpu_ce) begin n++; if (first < 0) first = i; end
    end
    check("press_ce_count", n, 1);
    check("press_ce_latency", first, 7);
    check("press_cycle_cnt", 32'(cycle_cnt), 1);

    // Bouncing press then held: still exactly one enable.
    n = 0;
    for (int i = 0; i < 6; i++) begin
      step_btn = (i % 2 == 0);
      tick(); n += int'(cpu_ce);
    end
    step_btn = 1;
    repeat (20) begin tick(); n += int'(cpu_ce); end
    check("bounce_ce_count", n, 1);
    step_btn = 0;
    repeat (12) tick();
    check("bounce_cycle_cnt", 32'(cycle_cnt), 2);

    // Table-driven run / halt / priority rows.
    do_reset();
    foreach (tbl[r]) begin
      run_sw = tbl[r].run_sw; halt_req = tbl[r].halt_req;
      tick();
      check($sformatf("tbl%0d_cpu_ce", r), 32'(cpu_ce), 32'(tbl[r].exp_ce));
      check($sformatf("tbl%0d_state", r), 32'(state), 32'(tbl[r].exp_state));
      check($sformatf("tbl%0d_halted", r), 32'(halted), 32'(tbl[r].exp_halted));
      check($sformatf("tbl%0d_cycle_cnt", r), 32'(cycle_cnt), 32'(tbl[r].exp_cnt));
    end

    // ebreak at the first slot, press while stopped, then step past it.
    run_sw = 1; halt_req = 1; n = 0;
    repeat (6) begin tick(); n += int'(cpu_ce); end
    check("ebreak_no_ce", n, 0);
    check("ebreak_state", 32'(state), 3);
    check("ebreak_halted", 32'(halted), 1);
    step_btn = 1; n = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 11) step_btn = 0;
      tick(); n += int'(cpu_ce);
    end
    check("stopped_press_ce", n, 0);
    check("stopped_press_state", 32'(state), 3);
    run_sw = 0;
    tick();
    check("unstop_state", 32'(state), 0);
    check("unstop_halted", 32'(halted), 0);
    step_btn = 1; n = 0; saw_step = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 11) step_btn = 0;
      tick(); n += int'(cpu_ce);
      if (state == 2'd1) saw_step = 1;
    end
    check("step_over_ce", n, 1);
    check("step_over_state_seen", 32'(saw_step), 1);
    check("step_over_cycle_cnt", 32'(cycle_cnt), 5);
    halt_req = 0;

    // Breakpoint at the current PC.
    pc = 32'h0000_0010; bp_addr = 32'h0000_0010; bp_valid = 1; run_sw = 1; n = 0;
    repeat (7) begin tick(); n += int'(cpu_ce); end
`ifdef CPU_BREAKPOINT_EN
    check("bp_ce_count", n, 0);
    check("bp_state", 32'(state), 3);
`else
    check("bp_ce_count", n, 2);
    check("bp_state", 32'(state), 2);
`endif
    run_sw = 0; bp_valid = 0; pc = '0;
    repeat (2) tick();
    check("bp_exit_state", 32'(state), 0);

    // Counter wrap after 17 enables.
    do_reset();
    run_sw = 1; n = 0; guard = 0;
    while (n < 17 && guard < 100) begin
      tick(); guard++;
      if (cpu_ce) n++;
    end
    check("wrap_ce_count", n, 17);
    tick();
    check("wrap_cycle_cnt", 32'(cycle_cnt), 1);

    // Reset mid-run, asserted while cpu_ce is high.
    guard = 0;
    while (!cpu_ce && guard < 10) begin tick(); guard++; end
    check("midrun_ce_before_rst", 32'(cpu_ce), 1);
    do_reset();

    // Randomized stimulus against the model.
    hold = 0;
    bp_addr = 32'h0000_0010;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 19) == 0) run_sw = ~run_sw;
      halt_req = ($urandom_range(0, 7) == 0);
      pc       = ($urandom_range(0, 3) == 0) ? 32'h0000_0010 : $urandom;
      bp_valid = $urandom_range(0, 1) == 1;
      if (hold == 0) begin
        step_btn = ~step_btn;
        hold = $urandom_range(1, 12);
      end else begin
        hold--;
      end
      tick();
      check_model();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_cpu_step_ctrl

// File: doc/cpu_step_ctrl.md
# cpu_step_ctrl

Clock-enable sequencer for the single-cycle RISC-V core on the FPGA board. It decides when the core advances one instruction: on a debounced pushbutton press (single-step), continuously at a divided rate (free-run), or not at all (halted on `ebreak`/`ecall` or a PC breakpoint). It sits between the board switches and buttons and the core's clock-enable input, and its state and cycle count drive board LEDs and the seven-segment display.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 16'd50000: cycles the synchronized button level must stay stable before it is accepted.
- `RUN_DIV`, 24'd1: free-run divider, one `cpu_ce` per `RUN_DIV` cycles; legal range 1 .. 2^24-1.
- `CNT_W`, 16: width of the retired-instruction counter.

Ports:
- `clk`  in  1  single system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `step_btn`  in  1  raw, asynchronous pushbutton.
- `run_sw`  in  1  level switch; 1 requests free-run.
- `halt_req`  in  1  from the core; the instruction at the current PC is `ebreak` or `ecall`.
- `pc`  in  32  current PC of the core.
- `bp_addr`  in  32  breakpoint address.
- `bp_valid`  in  1  breakpoint armed.
- `cpu_ce`  out  1  registered; the core executes one instruction on each cycle where this is high.
- `halted`  out  1  registered; high in S_STOP.
- `state`  out  2  registered FSM state, for the LEDs.
- `cycle_cnt`  out  CNT_W  registered count of `cpu_ce` pulses.

## Operation
- The button path uses `btn_debounce`: a 2-flop synchronizer, then a stability counter. It emits a one-cycle `step_pulse` on each accepted 0->1 transition.
- FSM encoding: S_HALT=0, S_STEP=1, S_RUN=2, S_STOP=3. Reset enters S_HALT.
- **S_HALT**
  - If `run_sw`=1, go to S_RUN. `run_sw` has priority over `step_pulse`.
  - Otherwise, if `step_pulse`=1, go to S_STEP.
- **S_STEP**
  - `cpu_ce`=1 for exactly one cycle, then return to S_HALT.
  - `halt_req` and the breakpoint are ignored, so stepping over an `ebreak` or a breakpoint is allowed.
- **S_RUN**
  - The divider `div` is cleared on entry and increments each cycle. At `div`==RUN_DIV-1 it wraps to 0 (the "issue slot").
  - stop_cond = `halt_req` | (breakpoint hit, see Configuration).
  - At an issue slot with stop_cond=1: no `cpu_ce`; go to S_STOP. The halting instruction is not executed.
  - At an issue slot with stop_cond=0: `cpu_ce`=1.
  - `run_sw`=0 in any cycle: go to S_HALT with no `cpu_ce`. If this coincides with stop_cond at an issue slot, S_STOP wins.
  - `step_pulse` is ignored.
- **S_STOP**
  - `halted`=1.
  - Leaves only when `run_sw`=0, going to S_HALT.
  - `step_pulse` is ignored.
- `cycle_cnt` increments by 1 on each clock edge that samples `cpu_ce`=1. It wraps from 2^CNT_W-1 to 0.

## Timing
- Reset values: `cpu_ce`=0, `halted`=0, `state`=0, `cycle_cnt`=0, `div`=0. The debounce counter and synchronizer also clear to 0.
- Reset asserted mid-run forces S_HALT immediately and asynchronously. `cpu_ce` drops in the same cycle.
- Button latency: the raw edge passes 2 synchronizer cycles, then DEBOUNCE_CYCLES stable cycles, then 1 cycle to `step_pulse`. `cpu_ce` is high in the cycle after `step_pulse`.
- Run start: the first `cpu_ce` occurs RUN_DIV cycles after `state` first reads S_RUN. It then recurs every RUN_DIV cycles.
- With RUN_DIV=1, `cpu_ce` is high every cycle in S_RUN.
- `halt_req` and `pc` are sampled combinationally in the issue-slot cycle.
- A breakpoint at the current PC re-stops at the next issue slot after re-entering S_RUN. The user single-steps past it.

## Configuration
- `CPU_BREAKPOINT_EN` defined:
  - breakpoint hit = `bp_valid` & (`pc`==`bp_addr`).
  - The hit is ORed into stop_cond.
- `CPU_BREAKPOINT_EN` undefined:
  - `bp_addr` and `bp_valid` remain as ports but are ignored.
  - stop_cond = `halt_req`.
  - No comparator is synthesized.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - the state encoding constants S_HALT, S_STEP, S_RUN, S_STOP;
  - the state width (2).
- Sub-module `btn_debounce`, parameterized by DEBOUNCE_CYCLES:
  - ports `clk`, `rst`, `btn_raw`, `step_pulse`.
  - It is reused for any other board button.

## Test plan
Bench uses DEBOUNCE_CYCLES=4, RUN_DIV=3, CNT_W=4.
- Reset, then a 10-cycle clean press -> exactly one `cpu_ce` pulse, 7 cycles after the press edge; `cycle_cnt`=1.
- Button bouncing 0/1 every cycle for 6 cycles, then held high -> exactly one `cpu_ce` pulse.
- `run_sw`=1 for 12 cycles from S_HALT -> `cpu_ce` pulses on cycles 3, 6, 9, 12 of S_RUN; `cycle_cnt`=4.
- In S_RUN, `halt_req`=1 at an issue slot -> no `cpu_ce` in that slot; `halted`=1 next cycle.
  - A press while stopped does nothing.
  - Then `run_sw`=0 and a press -> S_STEP, one `cpu_ce` past the `ebreak`.
- With `CPU_BREAKPOINT_EN`, `bp_valid`=1 and `bp_addr`=`pc`=0x0000_0010 -> S_RUN stops at the first issue slot.
  - Without the macro, the same stimulus runs free.
- Run 17 pulses -> `cycle_cnt` wraps to 1.
- Assert `rst` low mid-run -> all outputs 0 in the same cycle.
